// File: rtl/tr_pcm_seq.sv
// Sequencer/arbiter between the I/O decoder and tr_pcm. Shares the single tr_pcm
// register port between CPU accesses and a tick-paced playback streamer fed by a FIFO.
module tr_pcm_seq #(
   parameter int unsigned FIFO_DEPTH = 16,
   parameter int unsigned DIV_FAST   = 1368,
   parameter int unsigned DIV_SLOW   = 2736
) (
   input  logic                          clk21m,
   input  logic                          reset,
   input  logic                          cpu_req,
   input  logic                          cpu_wrt,
   input  logic                          cpu_adr,
   input  logic [7:0]                    cpu_dbo,
   output logic                          cpu_ack,
   output logic [7:0]                    cpu_dbi,
   input  logic                          smp_valid,
   input  logic [7:0]                    smp_data,
   output logic                          smp_ready,
   input  logic                          play_en,
   input  logic                          rate_sel,
   input  logic                          clr_status,
   output logic                          pcm_req,
   output logic                          pcm_wrt,
   output logic                          pcm_adr,
   output logic [7:0]                    pcm_dbo,
   input  logic                          pcm_ack,
   input  logic [7:0]                    pcm_dbi,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
   output logic                          underrun,
   output logic                          overrun
);

   localparam int unsigned AW      = $clog2(FIFO_DEPTH);
   localparam int unsigned DIV_MAX = (DIV_SLOW > DIV_FAST) ? DIV_SLOW : DIV_FAST;
   localparam int unsigned CW      = $clog2(DIV_MAX);

   typedef enum logic [1:0] {StIdle, StCpuX, StSmpX} state_t;

   state_t        state_q;
   logic [7:0]    mem_q [FIFO_DEPTH];
   logic [AW:0]   wptr_q, rptr_q;
   logic [CW-1:0] cnt_q, div_last;
   logic          rate_q;
   logic          full, empty, push, pop, tick;
   logic          cpu_pend_q, lat_wrt_q, lat_adr_q;
   logic [7:0]    lat_dbo_q;
   logic          smp_pend_q;
   logic [7:0]    smp_q;

   // Extra pointer bit makes the difference equal to the occupancy, MSB set only when full.
   assign fifo_level = wptr_q - rptr_q;
   assign full       = fifo_level[AW];
   assign empty      = (fifo_level == '0);
   assign smp_ready  = ~full;
   assign push       = smp_valid & ~full;
   assign pop        = tick & ~smp_pend_q & ~empty;

   assign div_last   = rate_q ? CW'(DIV_SLOW - 1) : CW'(DIV_FAST - 1);
   assign tick       = play_en & (cnt_q == div_last);

   // FIFO storage; no reset needed, occupancy is tracked by the pointers.
   always_ff @(posedge clk21m) begin
      if (push) mem_q[wptr_q[AW-1:0]] <= smp_data;
   end

   // FIFO pointers.
   always_ff @(posedge clk21m or posedge reset) begin
      if (reset) begin
         wptr_q <= '0;
         rptr_q <= '0;
      end else begin
         if (push) wptr_q <= wptr_q + (AW+1)'(1);
         if (pop)  rptr_q <= rptr_q + (AW+1)'(1);
      end
   end

   // Sample-rate divider; the rate select is only adopted at a wrap or while stopped.
   always_ff @(posedge clk21m or posedge reset) begin
      if (reset) begin
         cnt_q  <= '0;
         rate_q <= 1'b0;
      end else if (!play_en || tick) begin
         cnt_q  <= '0;
         rate_q <= rate_sel;
      end else begin
         cnt_q  <= cnt_q + CW'(1);
      end
   end

   // Request latching, status flags and the port sequencer with registered outputs.
   always_ff @(posedge clk21m or posedge reset) begin
      if (reset) begin
         state_q    <= StIdle;
         pcm_req    <= 1'b0;
         pcm_wrt    <= 1'b0;
         pcm_adr    <= 1'b0;
         pcm_dbo    <= 8'h00;
         cpu_ack    <= 1'b0;
         cpu_dbi    <= 8'h00;
         cpu_pend_q <= 1'b0;
         lat_wrt_q  <= 1'b0;
         lat_adr_q  <= 1'b0;
         lat_dbo_q  <= 8'h00;
         smp_pend_q <= 1'b0;
         smp_q      <= 8'h00;
         underrun   <= 1'b0;
         overrun    <= 1'b0;
      end else begin
         pcm_req <= 1'b0;
         cpu_ack <= 1'b0;

         // Set events are applied after the clear so they win.
         if (clr_status) begin
            underrun <= 1'b0;
            overrun  <= 1'b0;
         end
         if (tick && smp_pend_q) overrun <= 1'b1;
         if (tick && !smp_pend_q && empty) underrun <= 1'b1;

         if (cpu_req && !cpu_pend_q) begin
            cpu_pend_q <= 1'b1;
            lat_wrt_q  <= cpu_wrt;
            lat_adr_q  <= cpu_adr;
            lat_dbo_q  <= cpu_dbo;
         end

         // A sample not yet on the bus is dropped when playback stops.
         if (pop) begin
            smp_pend_q <= 1'b1;
            smp_q      <= mem_q[rptr_q[AW-1:0]];
         end else if (!play_en && state_q != StSmpX) begin
            smp_pend_q <= 1'b0;
         end

         unique case (state_q)
            StIdle: begin
               // A fresh strobe bypasses the latch so the bus sees it one cycle later.
               if (cpu_pend_q || cpu_req) begin
                  state_q <= StCpuX;
                  pcm_req <= 1'b1;
                  pcm_wrt <= cpu_pend_q ? lat_wrt_q : cpu_wrt;
                  pcm_adr <= cpu_pend_q ? lat_adr_q : cpu_adr;
                  pcm_dbo <= cpu_pend_q ? lat_dbo_q : cpu_dbo;
               end else if (smp_pend_q && play_en) begin
                  state_q <= StSmpX;
                  pcm_req <= 1'b1;
                  pcm_wrt <= 1'b1;
                  pcm_adr <= 1'b0;
                  pcm_dbo <= smp_q;
               end
            end
            StCpuX: begin
               if (pcm_ack) begin
                  cpu_ack    <= 1'b1;
                  cpu_dbi    <= pcm_dbi;
                  cpu_pend_q <= 1'b0;
                  state_q    <= StIdle;
               end
            end
            StSmpX: begin
               if (pcm_ack) begin
                  smp_pend_q <= 1'b0;
                  state_q    <= StIdle;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

endmodule
